// File: rtl/usart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer, mid-bit sampling and a valid/ready output.
// Reports framing errors as one-cycle pulses and keeps a sticky overrun flag.
module usart_rx #(
    parameter int unsigned clk_freq    = 16000000,
    parameter int unsigned baud_rate   = 115200,
    parameter int unsigned bit_period  = clk_freq / baud_rate,
    parameter int unsigned half_period = bit_period / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clear_err,
    output logic       rx_led
);

    localparam logic [15:0] HALF_LAST = 16'(half_period - 1);
    localparam logic [15:0] BIT_LAST  = 16'(bit_period - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        stop_good, stop_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                    if (rx_s_q) begin
                        stop_good = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = stop_bad;
        if (clear_err) overrun_d = 1'b0;
        if (data_valid_q && data_ready) data_valid_d = 1'b0;
        // A new byte overwrites only a slot that is empty or being consumed this cycle.
        if (stop_good) begin
            if (!data_valid_q || data_ready) begin
                data_d       = shreg_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        rx_led = (state_q != IDLE);
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- UART receiver, 8N1, LSB first. Counterpart of the team's 16 MHz / 115200 baud serial transmitter.
- Samples the asynchronous `rx` line, reassembles each byte and presents it on a valid/ready handshake for downstream logic.
- Flags framing errors and overruns. Drives an activity LED.

Parameters:
- clk_freq, 16000000, system clock frequency in Hz.
- baud_rate, 115200, line rate in bits per second.
- bit_period, clk_freq/baud_rate (138), clocks per bit (integer division).
- half_period, bit_period/2 (69), clocks from start-bit edge to mid-bit.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clock.
- data  output  8  received byte.
- data_valid  output  1  data holds an unconsumed byte.
- data_ready  input  1  consumer accepts data this cycle when data_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: byte completed while data_valid=1 and data_ready=0.
- clear_err  input  1  synchronous clear of overrun.
- rx_led  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - data=0, data_valid=0, frame_err=0, overrun=0, rx_led=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Input sync: rx passes through a 2-flop synchronizer giving rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: cnt increments each clock. At cnt=half_period-1:
    - rx_s=0: go to DATA, cnt=0, bit_idx=0.
    - rx_s=1: glitch; return to IDLE with no output.
  - DATA: at cnt=bit_period-1, shift rx_s into shreg[7] (shift right, so LSB first), set cnt=0, bit_idx++. After bit_idx 7 is sampled, go to STOP.
  - STOP: at cnt=bit_period-1, sample rx_s.
    - rx_s=1: deliver shreg (see below), go to IDLE.
    - rx_s=0: frame_err=1 for exactly one cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from being read as repeated 0x00 frames.
- Delivery, in the cycle after the stop sample:
  - data_valid=0: data<=shreg, data_valid<=1.
  - data_valid=1 and data_ready=1: data<=shreg, data_valid stays 1, no overrun.
  - data_valid=1 and data_ready=0: new byte dropped, data unchanged, overrun<=1.
- Handshake:
  - A transfer occurs on any cycle with data_valid=1 and data_ready=1.
  - data_valid drops the next cycle unless a delivery coincides.
  - data is stable while data_valid=1 and unaccepted.
  - data_ready while data_valid=0 has no effect.
- overrun clears only on clear_err=1 or reset. If clear_err and a new overrun occur in the same cycle, the overrun wins (stays 1).
- Latency: data_valid rises 2+half_period+9*bit_period ±2 clocks after the rx falling edge (1313±2 at defaults).
- Counters: cnt is 16 bits and never wraps, because it resets at its terminal count. bit_idx is 3 bits.
- Reset asserted mid-frame aborts immediately to reset values. After release, the receiver waits for rx_s=0 in IDLE, so a tail of the old frame may be misread as a start. This is accepted behaviour; the consumer resynchronises at the protocol level.
- Baud tolerance: mid-bit sampling tolerates ±3% rate mismatch across one frame.
- Back-to-back frames: a start bit immediately after the stop bit is detected. IDLE is entered half a bit before the stop bit ends.

Test Plan:
- Drive 0xA5 at 138 clocks/bit, data_ready=1 → data=0xA5, data_valid high for 1 cycle at 1313±2 clocks after the edge, frame_err=0, rx_led high during the frame only.
- rx low for 30 clocks then high → no data_valid, FSM back in IDLE, rx_led pulse ≤ half_period+3 clocks.
- Frame 0x3C with stop bit low, rx held low 2000 clocks, then high → one frame_err pulse, no data_valid, no second frame_err. Next frame 0x81 → data=0x81.
- Frames 0x11, then 0x22, back-to-back with data_ready=0 → data=0x11 retained, overrun=1. Assert data_ready → data_valid drops. Pulse clear_err → overrun=0.
- Back-to-back 0x00, 0xFF, 0x55 with data_ready=1 and no idle gap → three deliveries in order, no errors. Repeat at baud ±2% → same result.
- Assert reset mid-DATA of 0xF0 → all outputs 0 within the reset cycle. After release and line idle, send 0x0F → data=0x0F.
